id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter FWD_EN, default 1, 1 = operand forwarding enabled, 0 = register-file values used unmodified.
REQ-002 clk  input  1  core clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 dec_valid_ip / dec_ready_op  input / output  1 / 1  decode handshake; transfer when both high on a rising edge.
REQ-005 dec_alu_operator_ip  input  alu_opcode_e  decoded ALU operation.
REQ-006 dec_rs1_addr_ip, dec_rs2_addr_ip, dec_rd_addr_ip  input  5 each  source and destination register indices.
REQ-007 dec_rs1_data_ip, dec_rs2_data_ip, dec_imm_ip, dec_pc_ip  input  32 each  register-file reads, immediate, PC.
REQ-008 dec_op_a_sel_ip / dec_op_b_sel_ip  input  1 / 1  operand A: 0 = rs1, 1 = PC; operand B: 0 = rs2, 1 = imm.
REQ-009 dec_rd_we_ip, dec_is_load_ip  input  1 each  destination write enable; instruction is a load.
REQ-010 alu_result_ip  input  32  ALU result for the instruction currently held in this stage.
REQ-011 mem_rd_we_ip, mem_rd_addr_ip, mem_result_ip  input  1/5/32  MEM-stage destination and value.
REQ-012 wb_rd_we_ip, wb_rd_addr_ip, wb_result_ip  input  1/5/32  WB-stage destination and value.
REQ-013 ex_ready_ip  input  1  downstream accepts the held instruction this cycle.
REQ-014 flush_ip  input  1  branch/jump redirect; kill held and incoming instruction.
REQ-015 alu_enable_op, alu_operator_op, alu_operand_a_op, alu_operand_b_op  output  1/alu_opcode_e/32/32  registered ALU inputs; alu_enable_op is the stage valid bit.
REQ-016 ex_rd_addr_op, ex_rd_we_op, ex_is_load_op  output  5/1/1  registered destination info for MEM/WB.
REQ-017 stall_cnt_op  output  16  saturating count of load-use bubbles inserted.

Function
REQ-018 Stage SHALL be a single register slot; capture when dec_valid_ip & dec_ready_op, else hold or drain.
REQ-019 dec_ready_op SHALL = (~alu_enable_op | ex_ready_ip) & ~load_use, combinationally.
REQ-020 load_use SHALL be high when alu_enable_op & ex_is_load_op & ex_rd_addr_op != 0 and ex_rd_addr_op equals a used source (rs1 if op_a_sel=0, rs2 always when op_b_sel=0).
REQ-021 On load_use with ex_ready_ip, stage SHALL load a bubble (alu_enable_op=0, ex_rd_we_op=0) and increment stall_cnt_op, saturating at 0xFFFF.
REQ-022 On ex_ready_ip with no new capture and no load_use, alu_enable_op SHALL clear next cycle.
REQ-023 Forwarding (FWD_EN=1) SHALL select per source at capture with priority EX (held instr, non-load, rd_we) > MEM > WB > register file; index 0 never forwarded.
REQ-024 Operand A/B muxing SHALL be applied after forwarding; PC and immediate bypass forwarding.
REQ-025 flush_ip SHALL take precedence over all captures: next cycle alu_enable_op=0, ex_rd_we_op=0; dec_valid_ip ignored that cycle.
REQ-026 Latency SHALL be one cycle from accepted decode handshake to alu_enable_op high; throughput one instruction per cycle with ex_ready_ip high.
REQ-027 When held and ex_ready_ip low, all outputs SHALL remain stable.

Reset
REQ-028 While reset low: alu_enable_op=0, alu_operator_op=ALU_ADD, operands 0, ex_rd_addr_op=0, ex_rd_we_op=0, ex_is_load_op=0, stall_cnt_op=0; dec_ready_op=1 after release.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction without any output glitch reaching MEM.

Structure
REQ-030 alu_opcode_e and op_a/op_b select encodings SHALL reside in CORE_PKG; no new package.
REQ-031 One sub-module, fwd_mux, SHALL implement per-operand three-source priority forwarding, instantiated twice.

Verification
REQ-032 Back-to-back: addi x1,x0,5 then add x2,x1,x1 -> second captures operands 5,5 via EX forward.
REQ-033 lw x3 in EX, next add x4,x3,x0 -> dec_ready_op=0 one cycle, bubble, stall_cnt_op=1, then WB/MEM forward delivers load data.
REQ-034 MEM and WB both write x5 (0xA, 0xB) -> operand = 0xA.
REQ-035 rd=x0 with rd_we=1 in EX, consumer reads x0 -> operand = register-file value 0.
REQ-036 flush_ip with dec_valid_ip high -> next cycle alu_enable_op=0, ex_rd_we_op=0.
REQ-037 ex_ready_ip low 3 cycles -> outputs unchanged; reset low mid-hold -> all outputs at reset values.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core encodings: ALU opcodes, operand-select values and forwarding helpers.
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_opcode_e;

  localparam logic OP_A_RS1 = 1'b0;
  localparam logic OP_A_PC  = 1'b1;
  localparam logic OP_B_RS2 = 1'b0;
  localparam logic OP_B_IMM = 1'b1;

  // x0 is hard-wired zero, so a producer targeting it never supplies a value.
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX > MEM > WB > register file, index 0 never forwarded.
module fwd_mux
  import core_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]  i_src_addr,
  input  logic [31:0] i_rf_dat,
  input  logic        i_ex_vld,
  input  logic [4:0]  i_ex_addr,
  input  logic [31:0] i_ex_dat,
  input  logic        i_mem_we,
  input  logic [4:0]  i_mem_addr,
  input  logic [31:0] i_mem_dat,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_dat
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = fwd_hit(i_ex_vld, i_ex_addr, i_src_addr);
  assign w_mem_hit = fwd_hit(i_mem_we, i_mem_addr, i_src_addr);
  assign w_wb_hit  = fwd_hit(i_wb_we, i_wb_addr, i_src_addr);

  always_comb begin
    o_dat = i_rf_dat;
    if (FWD_EN) begin
      if (w_ex_hit)       o_dat = i_ex_dat;
      else if (w_mem_hit) o_dat = i_mem_dat;
      else if (w_wb_hit)  o_dat = i_wb_dat;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards operands at capture, inserts load-use bubbles, honours flush.
// One-cycle latency; holds steady while ex_ready_ip is low.
module id_ex_stage
  import core_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid_ip,
  output logic        dec_ready_op,
  input  alu_opcode_e dec_alu_operator_ip,
  input  logic [4:0]  dec_rs1_addr_ip,
  input  logic [4:0]  dec_rs2_addr_ip,
  input  logic [4:0]  dec_rd_addr_ip,
  input  logic [31:0] dec_rs1_data_ip,
  input  logic [31:0] dec_rs2_data_ip,
  input  logic [31:0] dec_imm_ip,
  input  logic [31:0] dec_pc_ip,
  input  logic        dec_op_a_sel_ip,
  input  logic        dec_op_b_sel_ip,
  input  logic        dec_rd_we_ip,
  input  logic        dec_is_load_ip,
  input  logic [31:0] alu_result_ip,
  input  logic        mem_rd_we_ip,
  input  logic [4:0]  mem_rd_addr_ip,
  input  logic [31:0] mem_result_ip,
  input  logic        wb_rd_we_ip,
  input  logic [4:0]  wb_rd_addr_ip,
  input  logic [31:0] wb_result_ip,
  input  logic        ex_ready_ip,
  input  logic        flush_ip,
  output logic        alu_enable_op,
  output alu_opcode_e alu_operator_op,
  output logic [31:0] alu_operand_a_op,
  output logic [31:0] alu_operand_b_op,
  output logic [4:0]  ex_rd_addr_op,
  output logic        ex_rd_we_op,
  output logic        ex_is_load_op,
  output logic [15:0] stall_cnt_op
);

  logic        r_vld;
  alu_opcode_e r_op;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [4:0]  r_rd;
  logic        r_rd_we;
  logic        r_ld;
  logic [15:0] r_stall;

  logic        w_ex_fwd_vld;
  logic        w_load_use;
  logic        w_capture;
  logic [31:0] w_rs1_fwd;
  logic [31:0] w_rs2_fwd;
  logic [31:0] w_opa;
  logic [31:0] w_opb;

  // A held load has no result yet, so it can never be an EX forwarding source.
  assign w_ex_fwd_vld = r_vld & r_rd_we & ~r_ld;

  assign w_load_use = r_vld & r_ld & (r_rd != 5'd0) &
                      (((dec_op_a_sel_ip == OP_A_RS1) & (r_rd == dec_rs1_addr_ip)) |
                       ((dec_op_b_sel_ip == OP_B_RS2) & (r_rd == dec_rs2_addr_ip)));

  assign dec_ready_op = (~r_vld | ex_ready_ip) & ~w_load_use;
  assign w_capture    = dec_valid_ip & dec_ready_op;

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs1 (
    .i_src_addr (dec_rs1_addr_ip),
    .i_rf_dat   (dec_rs1_data_ip),
    .i_ex_vld   (w_ex_fwd_vld),
    .i_ex_addr  (r_rd),
    .i_ex_dat   (alu_result_ip),
    .i_mem_we   (mem_rd_we_ip),
    .i_mem_addr (mem_rd_addr_ip),
    .i_mem_dat  (mem_result_ip),
    .i_wb_we    (wb_rd_we_ip),
    .i_wb_addr  (wb_rd_addr_ip),
    .i_wb_dat   (wb_result_ip),
    .o_dat      (w_rs1_fwd)
  );

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs2 (
    .i_src_addr (dec_rs2_addr_ip),
    .i_rf_dat   (dec_rs2_data_ip),
    .i_ex_vld   (w_ex_fwd_vld),
    .i_ex_addr  (r_rd),
    .i_ex_dat   (alu_result_ip),
    .i_mem_we   (mem_rd_we_ip),
    .i_mem_addr (mem_rd_addr_ip),
    .i_mem_dat  (mem_result_ip),
    .i_wb_we    (wb_rd_we_ip),
    .i_wb_addr  (wb_rd_addr_ip),
    .i_wb_dat   (wb_result_ip),
    .o_dat      (w_rs2_fwd)
  );

  assign w_opa = (dec_op_a_sel_ip == OP_A_PC)  ? dec_pc_ip  : w_rs1_fwd;
  assign w_opb = (dec_op_b_sel_ip == OP_B_IMM) ? dec_imm_ip : w_rs2_fwd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld   <= 1'b0;
      r_op    <= ALU_ADD;
      r_opa   <= 32'd0;
      r_opb   <= 32'd0;
      r_rd    <= 5'd0;
      r_rd_we <= 1'b0;
      r_ld    <= 1'b0;
      r_stall <= 16'd0;
    end else if (flush_ip) begin
      r_vld   <= 1'b0;
      r_rd_we <= 1'b0;
    end else if (w_capture) begin
      r_vld   <= 1'b1;
      r_op    <= dec_alu_operator_ip;
      r_opa   <= w_opa;
      r_opb   <= w_opb;
      r_rd    <= dec_rd_addr_ip;
      r_rd_we <= dec_rd_we_ip;
      r_ld    <= dec_is_load_ip;
    end else if (w_load_use && ex_ready_ip) begin
      r_vld   <= 1'b0;
      r_rd_we <= 1'b0;
      // Only count a bubble when a consumer was actually waiting behind the load.
      if (dec_valid_ip && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
    end else if (ex_ready_ip) begin
      r_vld   <= 1'b0;
      r_rd_we <= 1'b0;
    end
  end

  assign alu_enable_op    = r_vld;
  assign alu_operator_op  = r_op;
  assign alu_operand_a_op = r_opa;
  assign alu_operand_b_op = r_opb;
  assign ex_rd_addr_op    = r_rd;
  assign ex_rd_we_op      = r_rd_we;
  assign ex_is_load_op    = r_ld;
  assign stall_cnt_op     = r_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use stall, flush, hold and reset.
module tb_id_ex_stage;
  import core_pkg::*;

  logic        clk;
  logic        reset;
  logic        dec_valid_ip;
  logic        dec_ready_op;
  alu_opcode_e dec_alu_operator_ip;
  logic [4:0]  dec_rs1_addr_ip, dec_rs2_addr_ip, dec_rd_addr_ip;
  logic [31:0] dec_rs1_data_ip, dec_rs2_data_ip, dec_imm_ip, dec_pc_ip;
  logic        dec_op_a_sel_ip, dec_op_b_sel_ip, dec_rd_we_ip, dec_is_load_ip;
  logic [31:0] alu_result_ip;
  logic        mem_rd_we_ip, wb_rd_we_ip;
  logic [4:0]  mem_rd_addr_ip, wb_rd_addr_ip;
  logic [31:0] mem_result_ip, wb_result_ip;
  logic        ex_ready_ip, flush_ip;
  logic        alu_enable_op;
  alu_opcode_e alu_operator_op;
  logic [31:0] alu_operand_a_op, alu_operand_b_op;
  logic [4:0]  ex_rd_addr_op;
  logic        ex_rd_we_op, ex_is_load_op;
  logic [15:0] stall_cnt_op;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk                 (clk),
    .reset               (reset),
    .dec_valid_ip        (dec_valid_ip),
    .dec_ready_op        (dec_ready_op),
    .dec_alu_operator_ip (dec_alu_operator_ip),
    .dec_rs1_addr_ip     (dec_rs1_addr_ip),
    .dec_rs2_addr_ip     (dec_rs2_addr_ip),
    .dec_rd_addr_ip      (dec_rd_addr_ip),
    .dec_rs1_data_ip     (dec_rs1_data_ip),
    .dec_rs2_data_ip     (dec_rs2_data_ip),
    .dec_imm_ip          (dec_imm_ip),
    .dec_pc_ip           (dec_pc_ip),
    .dec_op_a_sel_ip     (dec_op_a_sel_ip),
    .dec_op_b_sel_ip     (dec_op_b_sel_ip),
    .dec_rd_we_ip        (dec_rd_we_ip),
    .dec_is_load_ip      (dec_is_load_ip),
    .alu_result_ip       (alu_result_ip),
    .mem_rd_we_ip        (mem_rd_we_ip),
    .mem_rd_addr_ip      (mem_rd_addr_ip),
    .mem_result_ip       (mem_result_ip),
    .wb_rd_we_ip         (wb_rd_we_ip),
    .wb_rd_addr_ip       (wb_rd_addr_ip),
    .wb_result_ip        (wb_result_ip),
    .ex_ready_ip         (ex_ready_ip),
    .flush_ip            (flush_ip),
    .alu_enable_op       (alu_enable_op),
    .alu_operator_op     (alu_operator_op),
    .alu_operand_a_op    (alu_operand_a_op),
    .alu_operand_b_op    (alu_operand_b_op),
    .ex_rd_addr_op       (ex_rd_addr_op),
    .ex_rd_we_op         (ex_rd_we_op),
    .ex_is_load_op       (ex_is_load_op),
    .stall_cnt_op        (stall_cnt_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input alu_opcode_e op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic asel,
                       input logic bsel, input logic we, input logic ld);
    dec_valid_ip        = 1'b1;
    dec_alu_operator_ip = op;
    dec_rs1_addr_ip     = rs1;
    dec_rs2_addr_ip     = rs2;
    dec_rd_addr_ip      = rd;
    dec_rs1_data_ip     = d1;
    dec_rs2_data_ip     = d2;
    dec_imm_ip          = imm;
    dec_pc_ip           = pc;
    dec_op_a_sel_ip     = asel;
    dec_op_b_sel_ip     = bsel;
    dec_rd_we_ip        = we;
    dec_is_load_ip      = ld;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_en"},    32'(alu_enable_op),    32'd0);
    chk({pfx, "_op"},    32'(alu_operator_op),  32'(ALU_ADD));
    chk({pfx, "_a"},     alu_operand_a_op,      32'd0);
    chk({pfx, "_b"},     alu_operand_b_op,      32'd0);
    chk({pfx, "_rd"},    32'(ex_rd_addr_op),    32'd0);
    chk({pfx, "_we"},    32'(ex_rd_we_op),      32'd0);
    chk({pfx, "_ld"},    32'(ex_is_load_op),    32'd0);
    chk({pfx, "_stall"}, 32'(stall_cnt_op),     32'd0);
  endtask

  initial begin
    reset = 1'b0;
    issue(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dec_valid_ip   = 1'b0;
    alu_result_ip  = 32'd0;
    mem_rd_we_ip   = 1'b0;
    mem_rd_addr_ip = 5'd0;
    mem_result_ip  = 32'd0;
    wb_rd_we_ip    = 1'b0;
    wb_rd_addr_ip  = 5'd0;
    wb_result_ip   = 32'd0;
    ex_ready_ip    = 1'b1;
    flush_ip       = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    #1 chk("rst_ready", 32'(dec_ready_op), 32'd1);

    // addi x1,x0,5 then add x2,x1,x1 with stale register-file data
    @(negedge clk);
    issue(ALU_ADD, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("addi_en", 32'(alu_enable_op), 32'd1);
    chk("addi_b",  alu_operand_b_op,   32'd5);
    chk("addi_rd", 32'(ex_rd_addr_op), 32'd1);
    @(negedge clk);
    issue(ALU_ADD, 5'd1, 5'd1, 5'd2, 32'hDEAD, 32'hDEAD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    alu_result_ip = 32'd5;
    tick();
    chk("exfwd_a", alu_operand_a_op, 32'd5);
    chk("exfwd_b", alu_operand_b_op, 32'd5);

    // lw x3 then add x4,x3,x0: one bubble, then MEM forward
    @(negedge clk);
    issue(ALU_ADD, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h100, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    alu_result_ip = 32'd10;
    tick();
    chk("lw_ld", 32'(ex_is_load_op), 32'd1);
    @(negedge clk);
    issue(ALU_ADD, 5'd3, 5'd0, 5'd4, 32'h111, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    alu_result_ip = 32'h100;
    #1 chk("lu_ready", 32'(dec_ready_op), 32'd0);
    tick();
    chk("bub_en",    32'(alu_enable_op), 32'd0);
    chk("bub_we",    32'(ex_rd_we_op),   32'd0);
    chk("bub_stall", 32'(stall_cnt_op),  32'd1);
    @(negedge clk);
    mem_rd_we_ip = 1'b1; mem_rd_addr_ip = 5'd3; mem_result_ip = 32'hCAFE0001;
    #1 chk("lu_ready2", 32'(dec_ready_op), 32'd1);
    tick();
    chk("lu_en", 32'(alu_enable_op), 32'd1);
    chk("lu_a",  alu_operand_a_op,   32'hCAFE0001);
    chk("lu_b",  alu_operand_b_op,   32'd0);

    // MEM beats WB on x5; then EX beats MEM on x6 while WB supplies x5
    @(negedge clk);
    mem_rd_we_ip = 1'b1; mem_rd_addr_ip = 5'd5; mem_result_ip = 32'hA;
    wb_rd_we_ip  = 1'b1; wb_rd_addr_ip  = 5'd5; wb_result_ip  = 32'hB;
    issue(ALU_ADD, 5'd5, 5'd5, 5'd6, 32'h77, 32'h77, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    alu_result_ip = 32'h44;
    tick();
    chk("memwb_a", alu_operand_a_op, 32'hA);
    chk("memwb_b", alu_operand_b_op, 32'hA);
    @(negedge clk);
    mem_rd_addr_ip = 5'd6; mem_result_ip = 32'h99;
    issue(ALU_SUB, 5'd6, 5'd5, 5'd7, 32'h77, 32'h77, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    alu_result_ip = 32'h66;
    tick();
    chk("exmem_a", alu_operand_a_op,     32'h66);
    chk("wb_b",    alu_operand_b_op,     32'hB);
    chk("sub_op",  32'(alu_operator_op), 32'(ALU_SUB));

    // rd=x0 producer everywhere; consumer of x0 must see register-file zero
    @(negedge clk);
    mem_rd_we_ip = 1'b0; wb_rd_we_ip = 1'b0;
    issue(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    mem_rd_we_ip = 1'b1; mem_rd_addr_ip = 5'd0; mem_result_ip = 32'h55;
    wb_rd_we_ip  = 1'b1; wb_rd_addr_ip  = 5'd0; wb_result_ip  = 32'h56;
    issue(ALU_ADD, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    alu_result_ip = 32'd9;
    tick();
    chk("x0_a", alu_operand_a_op, 32'd0);
    chk("x0_b", alu_operand_b_op, 32'd0);

    // PC and immediate bypass forwarding even when rs matches EX rd
    @(negedge clk);
    mem_rd_we_ip = 1'b0; wb_rd_we_ip = 1'b0;
    issue(ALU_OR, 5'd9, 5'd9, 5'd10, 32'h31, 32'h32, 32'h20, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b0);
    alu_result_ip = 32'h123;
    tick();
    chk("pc_a",  alu_operand_a_op, 32'h1000);
    chk("imm_b", alu_operand_b_op, 32'h20);

    // downstream stall for 3 cycles: everything frozen
    @(negedge clk);
    ex_ready_ip = 1'b0;
    issue(ALU_XOR, 5'd1, 5'd2, 5'd11, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("hold_ready", 32'(dec_ready_op), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_en", 32'(alu_enable_op),   32'd1);
      chk("hold_op", 32'(alu_operator_op), 32'(ALU_OR));
      chk("hold_a",  alu_operand_a_op,     32'h1000);
      chk("hold_b",  alu_operand_b_op,     32'h20);
      chk("hold_rd", 32'(ex_rd_addr_op),   32'd10);
    end

    // drain with nothing new
    @(negedge clk);
    ex_ready_ip  = 1'b1;
    dec_valid_ip = 1'b0;
    tick();
    chk("drain_en", 32'(alu_enable_op), 32'd0);

    // flush kills both held and incoming
    @(negedge clk);
    issue(ALU_ADD, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("pre_flush_en", 32'(alu_enable_op), 32'd1);
    @(negedge clk);
    issue(ALU_ADD, 5'd0, 5'd0, 5'd13, 32'd0, 32'd0, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    flush_ip = 1'b1;
    tick();
    chk("flush_en", 32'(alu_enable_op), 32'd0);
    chk("flush_we", 32'(ex_rd_we_op),   32'd0);

    // reset asserted while a load is held with a dependent consumer waiting
    @(negedge clk);
    flush_ip = 1'b0;
    mem_rd_we_ip = 1'b0; wb_rd_we_ip = 1'b0;
    issue(ALU_ADD, 5'd0, 5'd0, 5'd14, 32'd0, 32'd0, 32'h200, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    ex_ready_ip = 1'b0;
    issue(ALU_ADD, 5'd14, 5'd0, 5'd15, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("st_ready", 32'(dec_ready_op), 32'd0);
    tick();
    chk("st_rd",    32'(ex_rd_addr_op), 32'd14);
    chk("st_stall", 32'(stall_cnt_op),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    chk("mid_ready", 32'(dec_ready_op), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    dec_valid_ip = 1'b0;
    ex_ready_ip = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
